// File: rtl/mem_pkg.sv
// Shared types and constants for the unified instruction/data memory responder.
package mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [WORD_W-1:0] ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } t_MemState;

endpackage

// File: rtl/mem_array.sv
// Byte-enable word array: one synchronous write port, one combinational read port.
module mem_array
  import mem_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_c_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Storage has no reset; the responder clears it word by word after reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_c_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory with valid/ready request and response channels,
// programmable wait states, byte-enable stores and bad-access flagging.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_ReqValid,
  output logic              o_ReqReady,
  input  logic              i_ReqWrite,
  input  logic [WORD_W-1:0] i_ReqAddr,
  input  logic [WORD_W-1:0] i_ReqWData,
  input  logic [BE_W-1:0]   i_ReqByteEn,
  output logic              o_RspValid,
  input  logic              i_RspReady,
  output logic [WORD_W-1:0] o_RspRData,
  output logic              o_RspErr
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;

  t_MemState         state_q, state_d;
  logic [AW-1:0]     clr_q, clr_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic              wr_q, wr_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              cur_write_c;
  logic [WORD_W-1:0] cur_addr_c;
  logic [WORD_W-1:0] cur_wdata_c;
  logic [BE_W-1:0]   cur_be_c;
  logic              acc_err_c;
  logic [AW-1:0]     word_idx_c;
  logic              commit_c;
  logic              mem_we_c;
  logic [AW-1:0]     mem_waddr_c;
  logic [WORD_W-1:0] mem_wdata_c;
  logic [BE_W-1:0]   mem_be_c;
  logic [WORD_W-1:0] mem_rdata_c;

  // With zero wait states the commit happens on the accept edge, so it must
  // see the live request inputs rather than the not-yet-captured copy.
  always_comb begin
    if (state_q == IDLE) begin
      cur_write_c = i_ReqWrite;
      cur_addr_c  = i_ReqAddr;
      cur_wdata_c = i_ReqWData;
      cur_be_c    = i_ReqByteEn;
    end else begin
      cur_write_c = wr_q;
      cur_addr_c  = addr_q;
      cur_wdata_c = wdata_q;
      cur_be_c    = be_q;
    end
  end

  assign acc_err_c  = (cur_addr_c[1:0] != 2'b00) ||
                      (cur_addr_c[WORD_W-1:2] >= (WORD_W-2)'(DEPTH_WORDS));
  assign word_idx_c = cur_addr_c[AW+1:2];

  assign mem_waddr_c = (state_q == INIT) ? clr_q : word_idx_c;
  assign mem_wdata_c = (state_q == INIT) ? '0 : cur_wdata_c;
  assign mem_be_c    = (state_q == INIT) ? '1 : cur_be_c;

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_mem_array (
    .clk_i     (i_Clk),
    .we_i      (mem_we_c),
    .waddr_i   (mem_waddr_c),
    .wdata_i   (mem_wdata_c),
    .be_i      (mem_be_c),
    .raddr_i   (word_idx_c),
    .rdata_c_o (mem_rdata_c)
  );

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= INIT;
      clr_q   <= '0;
      wait_q  <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      wait_q  <= wait_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    wait_d   = wait_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    valid_d  = valid_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    commit_c = 1'b0;
    mem_we_c = 1'b0;

    case (state_q)
      INIT: begin
        mem_we_c = 1'b1;
        if (clr_q == AW'(DEPTH_WORDS - 1)) begin
          state_d = IDLE;
        end else begin
          clr_d = clr_q + AW'(1);
        end
      end
      IDLE: begin
        if (i_ReqValid && ready_q) begin
          wr_d    = i_ReqWrite;
          addr_d  = i_ReqAddr;
          wdata_d = i_ReqWData;
          be_d    = i_ReqByteEn;
          if (WAIT_CYCLES == 0) begin
            commit_c = 1'b1;
          end else begin
            state_d = WAIT;
            wait_d  = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (wait_q == '0) begin
          commit_c = 1'b1;
        end else begin
          wait_d = wait_q - CW'(1);
        end
      end
      RESP: begin
        if (i_RspReady) begin
          state_d = IDLE;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase

    // Commit: the store lands and load data is latched on the edge into RESP.
    if (commit_c) begin
      state_d  = RESP;
      valid_d  = 1'b1;
      err_d    = acc_err_c;
      rdata_d  = (acc_err_c || cur_write_c) ? ERR_RDATA : mem_rdata_c;
      mem_we_c = cur_write_c && !acc_err_c;
    end

    ready_d = (state_d == IDLE);
  end

  assign o_ReqReady = ready_q;
  assign o_RspValid = valid_q;
  assign o_RspRData = rdata_q;
  assign o_RspErr   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: dut 0 runs with two wait states, dut 1 with none.
module tb_mem_responder;

  localparam int unsigned D  = 16;
  localparam int unsigned WA = 2;
  localparam int unsigned WB = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n, req_valid, req_ready, req_write;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][3:0]  req_be;
  logic [1:0]       rsp_valid, rsp_ready, rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  bit   in_rsp[2];
  bit   hs_pending[2];

  mem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(WA)) u_dut_a (
    .i_Clk(clk), .i_Reset(rst_n[0]), .i_ReqValid(req_valid[0]), .o_ReqReady(req_ready[0]),
    .i_ReqWrite(req_write[0]), .i_ReqAddr(req_addr[0]), .i_ReqWData(req_wdata[0]),
    .i_ReqByteEn(req_be[0]), .o_RspValid(rsp_valid[0]), .i_RspReady(rsp_ready[0]),
    .o_RspRData(rsp_rdata[0]), .o_RspErr(rsp_err[0])
  );

  mem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(WB)) u_dut_b (
    .i_Clk(clk), .i_Reset(rst_n[1]), .i_ReqValid(req_valid[1]), .o_ReqReady(req_ready[1]),
    .i_ReqWrite(req_write[1]), .i_ReqAddr(req_addr[1]), .i_ReqWData(req_wdata[1]),
    .i_ReqByteEn(req_be[1]), .o_RspValid(rsp_valid[1]), .i_RspReady(rsp_ready[1]),
    .o_RspRData(rsp_rdata[1]), .o_RspErr(rsp_err[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic bit q_empty(input int i);
    return (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
  endfunction

  function automatic void q_push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic exp_t q_pop(input int i);
    return (i == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  // Monitor: pops an expectation when a response first appears, then checks
  // it stays stable until the handshake and that IDLE follows immediately.
  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        in_rsp[i]     = 1'b0;
        hs_pending[i] = 1'b0;
      end else if (hs_pending[i]) begin
        check($sformatf("dut%0d_valid_after_hs", i), 32'(rsp_valid[i]), 32'd0);
        check($sformatf("dut%0d_ready_after_hs", i), 32'(req_ready[i]), 32'd1);
        hs_pending[i] = 1'b0;
      end else if (rsp_valid[i]) begin
        if (!in_rsp[i]) begin
          in_rsp[i] = 1'b1;
          if (q_empty(i)) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_unexpected_rsp: got rdata 0x%08h err %0b, expected no response",
                     i, rsp_rdata[i], rsp_err[i]);
            cur[i].rdata = rsp_rdata[i];
            cur[i].err   = rsp_err[i];
            cur[i].acc   = cyc;
          end else begin
            cur[i] = q_pop(i);
            check($sformatf("dut%0d_rdata", i), rsp_rdata[i], cur[i].rdata);
            check($sformatf("dut%0d_err", i), 32'(rsp_err[i]), 32'(cur[i].err));
            check($sformatf("dut%0d_latency", i), 32'(cyc + 1 - cur[i].acc),
                  (i == 0) ? 32'(WA + 1) : 32'(WB + 1));
          end
        end else begin
          check($sformatf("dut%0d_stable_rdata", i), rsp_rdata[i], cur[i].rdata);
          check($sformatf("dut%0d_stable_err", i), 32'(rsp_err[i]), 32'(cur[i].err));
          check($sformatf("dut%0d_ready_in_resp", i), 32'(req_ready[i]), 32'd0);
        end
        if (rsp_ready[i]) begin
          in_rsp[i]     = 1'b0;
          hs_pending[i] = 1'b1;
        end
      end else if (in_rsp[i]) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_valid_dropped: got valid 0, expected 1 until handshake", i);
        in_rsp[i] = 1'b0;
      end
    end
  end

  // Issues one request, pushes its expectation at accept and waits for the response.
  task automatic do_req(input int i, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input bit stall, output int waits);
    exp_t e;
    int   t;
    req_valid[i] = 1'b1;
    req_write[i] = wr;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    req_be[i]    = be;
    rsp_ready[i] = !stall;
    waits = 0;
    while (!req_ready[i] && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready[i]) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_accept_timeout: got ready 0, expected 1 within 200 cycles", i);
      req_valid[i] = 1'b0;
      return;
    end
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.acc   = cyc + 1;
    q_push(i, e);
    @(negedge clk);
    req_valid[i] = 1'b0;
    if (stall) begin
      t = 0;
      while (!rsp_valid[i] && t < 50) begin
        @(negedge clk);
        t++;
      end
      repeat (5) @(negedge clk);
      rsp_ready[i] = 1'b1;
    end
    t = 0;
    while ((!q_empty(i) || in_rsp[i] || hs_pending[i]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_rsp_timeout: got no completed response, expected one within 100 cycles", i);
    end
  endtask

  initial begin
    int w;
    rst_n     = '0;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = '1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d_rst_ready", i), 32'(req_ready[i]), 32'd0);
      check($sformatf("dut%0d_rst_valid", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("dut%0d_rst_rdata", i), rsp_rdata[i], 32'd0);
      check($sformatf("dut%0d_rst_err", i), 32'(rsp_err[i]), 32'd0);
    end

    // Request held during INIT; accepted only once the clear finishes.
    rst_n[0] = 1'b1;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, w);
    check("init_ready_low_cycles", 32'(w), 32'(D));

    do_req(0, 1'b1, 32'h4,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0, w);
    do_req(0, 1'b0, 32'h4,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b0, w);
    do_req(0, 1'b1, 32'h4,  32'h000000AA, 4'h1, 32'h0,        1'b0, 1'b0, w);
    do_req(0, 1'b0, 32'h4,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 1'b0, w);
    do_req(0, 1'b1, 32'h4,  32'h55555555, 4'h0, 32'h0,        1'b0, 1'b0, w);
    do_req(0, 1'b0, 32'h4,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 1'b0, w);
    do_req(0, 1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 1'b0, w);
    do_req(0, 1'b0, 32'h6,  32'h0,        4'h0, 32'h0,        1'b1, 1'b0, w);
    do_req(0, 1'b1, 32'(D*4), 32'hFFFFFFFF, 4'hF, 32'h0,      1'b1, 1'b0, w);
    do_req(0, 1'b0, 32'h80000000, 32'h0,  4'h0, 32'h0,        1'b1, 1'b0, w);
    do_req(0, 1'b0, 32'h3C, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1'b0, w);
    do_req(0, 1'b0, 32'h0,  32'h0,        4'h0, 32'h0,        1'b0, 1'b0, w);
    // Response back-pressure for five cycles.
    do_req(0, 1'b0, 32'h4,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 1'b1, w);

    // Reset while a store sits in WAIT: no response, and memory re-cleared.
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h8;
    req_wdata[0] = 32'h12345678;
    req_be[0]    = 4'hF;
    w = 0;
    while (!req_ready[0] && w < 200) begin
      w++;
      @(negedge clk);
    end
    check("midreset_store_accepted", 32'(req_ready[0]), 32'd1);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n[0]     = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_no_valid", 32'(rsp_valid[0]), 32'd0);
    rst_n[0] = 1'b1;
    do_req(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, w);
    check("reinit_ready_low_cycles", 32'(w), 32'(D));
    do_req(0, 1'b0, 32'h4, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, w);

    // Zero wait states.
    rst_n[1] = 1'b1;
    do_req(1, 1'b1, 32'hC, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b0, w);
    check("dut1_init_ready_low_cycles", 32'(w), 32'(D));
    do_req(1, 1'b0, 32'hC, 32'h0, 4'h0, 32'h11223344, 1'b0, 1'b0, w);
    do_req(1, 1'b1, 32'hC, 32'hFF00FF00, 4'b1010, 32'h0, 1'b0, 1'b0, w);
    do_req(1, 1'b0, 32'hC, 32'h0, 4'h0, 32'hFF22FF44, 1'b0, 1'b0, w);
    do_req(1, 1'b0, 32'h1, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0, w);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed unified instruction/data memory that answers load, store and fetch requests from a multi-cycle core datapath.
- Uses a valid/ready request channel and a valid/ready response channel.
- Inserts a programmable number of wait states, supports byte-enable stores and flags bad accesses.
- Clears its array after reset, so simulation and FPGA images start from a known state.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- WAIT_CYCLES, 2, wait states between request accept and response; range 0–15.

Ports:
- i_Clk  in  1  clock; all state changes on its rising edge.
- i_Reset  in  1  asynchronous, active-low reset.
- i_ReqValid  in  1  request present.
- o_ReqReady  out  1  responder can accept a request.
- i_ReqWrite  in  1  1 = store, 0 = load/fetch.
- i_ReqAddr  in  32  byte address.
- i_ReqWData  in  32  store data.
- i_ReqByteEn  in  4  store lane enables; bit n covers bits [8n+7:8n].
- o_RspValid  out  1  response present.
- i_RspReady  in  1  requester accepts the response.
- o_RspRData  out  32  load data; 0 for stores and errors.
- o_RspErr  out  1  access was misaligned or out of range.

Behaviour:
- Reset asserted (i_Reset=0):
  - state goes to INIT and the clear counter goes to 0;
  - o_ReqReady=0, o_RspValid=0, o_RspRData=0, o_RspErr=0;
  - captured request registers are cleared.
- Reset is asynchronous on assertion; the first state change after release occurs on the next rising edge.
- States: INIT, IDLE, WAIT, RESP.
- INIT:
  - writes 0 to word[clear counter] once per cycle;
  - after word DEPTH_WORDS-1, goes to IDLE;
  - takes exactly DEPTH_WORDS cycles;
  - o_ReqReady=0 throughout.
- IDLE:
  - o_ReqReady=1;
  - on i_ReqValid & o_ReqReady, captures write, addr, wdata and byteen;
  - goes to WAIT with the wait counter = WAIT_CYCLES-1, or straight to commit if WAIT_CYCLES=0;
  - no other state accepts requests.
- WAIT:
  - decrements the wait counter each cycle;
  - commits when the counter is 0.
- Commit (the transition edge into RESP):
  - error = (addr[1:0]≠0) or (addr[31:2] ≥ DEPTH_WORDS);
  - store without error: only enabled lanes of word[addr[31:2]] are updated; byteen=0 is a no-op that still gets a normal response;
  - load without error: o_RspRData ← word[addr[31:2]];
  - error: memory is unchanged, o_RspRData ← 0, o_RspErr ← 1.
- RESP:
  - o_RspValid=1;
  - o_RspRData and o_RspErr stay stable until the handshake;
  - on i_RspReady, goes to IDLE and clears o_RspValid and o_RspErr.
- Latency: accept edge to o_RspValid high is WAIT_CYCLES+1 cycles.
  - Minimum spacing between accepts is WAIT_CYCLES+2 cycles, since there is at most one outstanding request.
- Request inputs are don't-care outside IDLE.
- A load that follows a store to the same word returns the stored data, because the store committed before its response.
- Reset mid-transaction: the pending request is dropped with no response.
  - A store that reset interrupts before its commit edge never modifies memory.
  - INIT then re-clears the whole array.
- Counter widths: clear counter is $clog2(DEPTH_WORDS); wait counter is 4 bits. Neither wraps under legal parameters.

Decomposition:
- Package mem_pkg holds:
  - state enum t_MemState {INIT, IDLE, WAIT, RESP};
  - constants WORD_W=32 and BE_W=4;
  - ERR_RDATA=32'h0.
- One sub-module, mem_array:
  - synchronous-write, byte-enable word array;
  - one write port shared between the INIT clear and stores, plus one read port;
  - no reset on storage.
- The FSM, counters, request capture and response registers stay in mem_responder.

Test Plan:
- Release reset, hold i_ReqValid=1 → o_ReqReady stays 0 for exactly DEPTH_WORDS cycles; a load of 0x0000_0010 then returns 0x0000_0000 with err=0.
- Store 0xDEADBEEF at 0x0000_0004 with byteen=4'hF, then load 0x0000_0004 → 0xDEADBEEF; each response arrives exactly WAIT_CYCLES+1 cycles after its accept.
- Store 0x0000_00AA to 0x0000_0004 with byteen=4'b0001 over 0xDEADBEEF → a following load returns 0xDEADBEAA.
- Load 0x0000_0006 (misaligned), then store to byte address DEPTH_WORDS*4 (out of range) → both give err=1 and rdata=0; a following load of word DEPTH_WORDS-1 shows it unchanged.
- Hold i_RspReady=0 for 5 cycles during RESP → o_RspValid, o_RspRData and o_RspErr stay stable and o_ReqReady=0; after the handshake, IDLE is re-entered next cycle.
- Assert reset during WAIT of a store of 0x12345678 to 0x0000_0008 → no response; after INIT, a load of 0x0000_0008 returns 0. Also rerun with WAIT_CYCLES=0 → latency of 1 cycle.
